// File: rtl/hall_sequence_gen.sv
// Hall-sensor emulator: steps {H3,H2,H1} through the 6-sector sequence at a
// programmable rate/direction and watches the returned gate drives for shoot-through.
module hall_sequence_gen #(
  parameter int STEP_W = 16,
  parameter int REV_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              DIR,
  input  logic [STEP_W-1:0] STEP_CNT,
  input  logic              FAULT_INJ,
  input  logic              CLR_FLT,
  input  logic              A_OUT,
  input  logic              AA_OUT,
  input  logic              B_OUT,
  input  logic              BB_OUT,
  input  logic              C_OUT,
  input  logic              CC_OUT,
  output logic              H1,
  output logic              H2,
  output logic              H3,
  output logic [2:0]        SECTOR,
  output logic              STEP_STB,
  output logic [REV_W-1:0]  REV_CNT,
  output logic              SHOOT_FLT
);

  logic [STEP_W-1:0] count_q, count_d;
  logic [STEP_W-1:0] period_q, period_d;
  logic              per_vld_q, per_vld_d;
  logic [2:0]        sector_q, sector_d;
  logic [2:0]        h_q, h_d;
  logic              stb_q, stb_d;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic [5:0]        gate_q, gate_d;
  logic              flt_q, flt_d;

  logic [STEP_W-1:0] step_cnt_eff;
  logic [STEP_W-1:0] period_cur;
  logic              boundary;
  logic              viol;

  function automatic logic [2:0] hall_code(input logic [2:0] s);
    case (s)
      3'd0:    hall_code = 3'b001;
      3'd1:    hall_code = 3'b101;
      3'd2:    hall_code = 3'b100;
      3'd3:    hall_code = 3'b110;
      3'd4:    hall_code = 3'b010;
      3'd5:    hall_code = 3'b011;
      default: hall_code = 3'b001;
    endcase
  endfunction

  always_comb begin
    step_cnt_eff = (STEP_CNT == '0) ? STEP_W'(1) : STEP_CNT;
    // Before the first enabled cycle there is no latched period; use the live input.
    period_cur   = per_vld_q ? period_q : step_cnt_eff;
    boundary     = EN && (count_q == period_cur - STEP_W'(1));

    count_d   = count_q;
    period_d  = period_q;
    per_vld_d = per_vld_q;
    sector_d  = sector_q;
    rev_d     = rev_q;
    stb_d     = 1'b0;

    if (EN) begin
      per_vld_d = 1'b1;
      period_d  = period_cur;
      if (boundary) begin
        count_d  = '0;
        period_d = step_cnt_eff;
        stb_d    = 1'b1;
        if (!DIR) begin
          sector_d = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
          if (sector_q == 3'd5) rev_d = rev_q + REV_W'(1);
        end else begin
          sector_d = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
          if (sector_q == 3'd0) rev_d = rev_q - REV_W'(1);
        end
      end else begin
        count_d = count_q + STEP_W'(1);
      end
    end

    h_d = FAULT_INJ ? 3'b000 : hall_code(sector_d);

    gate_d = {A_OUT, AA_OUT, B_OUT, BB_OUT, C_OUT, CC_OUT};
    viol   = (gate_q[5] & gate_q[4]) | (gate_q[3] & gate_q[2]) | (gate_q[1] & gate_q[0]);
    // A fresh violation outranks a simultaneous clear.
    flt_d  = viol | (flt_q & ~CLR_FLT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q   <= '0;
      period_q  <= '0;
      per_vld_q <= 1'b0;
      sector_q  <= 3'd0;
      h_q       <= 3'b001;
      stb_q     <= 1'b0;
      rev_q     <= '0;
      gate_q    <= '0;
      flt_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      period_q  <= period_d;
      per_vld_q <= per_vld_d;
      sector_q  <= sector_d;
      h_q       <= h_d;
      stb_q     <= stb_d;
      rev_q     <= rev_d;
      gate_q    <= gate_d;
      flt_q     <= flt_d;
    end
  end

  assign {H3, H2, H1} = h_q;
  assign SECTOR       = sector_q;
  assign STEP_STB     = stb_q;
  assign REV_CNT      = rev_q;
  assign SHOOT_FLT    = flt_q;

endmodule
